// File: rtl/clk_ctrl_pkg.sv
// Shared encodings for the step clock controller: MODE input codes, FSM states,
// and the tick counter width.
package clk_ctrl_pkg;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_HALT = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  localparam int TICK_W = 16;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  // The unused MODE code 11 behaves as HALT.
  function automatic state_e mode_to_state(input logic [1:0] mode);
    state_e st;
    case (mode)
      MODE_RUN:  st = ST_RUN;
      MODE_STEP: st = ST_STEP;
      default:   st = ST_HALT;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/btn_step_sync.sv
// Push-button front end: synchroniser chain, rising-edge detect and a lockout
// counter that turns each accepted press into one registered accept pulse.
module btn_step_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic accept_pulse_o
);

  localparam int LOCK_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [LOCK_W-1:0] LOCK_RELOAD = LOCK_W'(DEB_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [LOCK_W-1:0]      lock_q, lock_d;
  logic                   accept_q;
  logic                   rise;
  logic                   accept;

  assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign accept = rise && (lock_q == '0);

  // Edges arriving while the lockout is non-zero are dropped, not queued.
  always_comb begin
    lock_d = lock_q;
    if (accept) begin
      lock_d = LOCK_RELOAD;
    end else if (lock_q != '0) begin
      lock_d = lock_q - LOCK_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      lock_q   <= '0;
      accept_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_i};
      prev_q   <= sync_q[SYNC_STAGES-1];
      lock_q   <= lock_d;
      accept_q <= accept;
    end
  end

  assign accept_pulse_o = accept_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// Slow-clock generator with RUN / HALT / STEP modes: power-of-two divider,
// single-step from a debounced button, square-wave SCLK and a tick counter.
module step_clock_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int CNT_W       = 27,
  parameter int SEL_W       = 4,
  parameter int BASE_DIV    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 1_000_000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [SEL_W-1:0]  RATE_SEL,
  input  logic [1:0]        MODE,
  input  logic              STEP_BTN,
  output logic              SCLK_EN,
  output logic              SCLK,
  output logic [TICK_W-1:0] TICK_CNT,
  output logic              RUNNING
);

  localparam int DW = CNT_W + SEL_W;
  localparam logic [DW-1:0]    D_MAX_W = {{SEL_W{1'b0}}, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] D_MAX   = {CNT_W{1'b1}};

  logic [1:0]        mode_q;
  logic [SEL_W-1:0]  rate_q, rate_prev_q;
  state_e            state_q, state_d;
  logic              running_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sclk_en_q, sclk_q;
  logic [TICK_W-1:0] tick_cnt_q;

  logic [DW-1:0]     div_wide;
  logic [CNT_W-1:0]  div;
  logic              rate_chg, at_end, run_tick, step_tick, tick, accept;

  btn_step_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYC    (DEB_CYC)
  ) u_btn (
    .clk_i         (CLK),
    .rst_i         (RST),
    .btn_i         (STEP_BTN),
    .accept_pulse_o(accept)
  );

  // Large selects would shift the base past the working width; those already
  // exceed the counter range, so they saturate along with in-range overflows.
  assign div_wide = DW'(BASE_DIV) << rate_q;
  assign div      = (32'(rate_q) >= 32'(CNT_W) || div_wide > D_MAX_W)
                    ? D_MAX : div_wide[CNT_W-1:0];

  assign state_d   = mode_to_state(mode_q);
  assign rate_chg  = (rate_q != rate_prev_q);
  assign at_end    = (cnt_q >= div - CNT_W'(1));
  assign run_tick  = (state_q == ST_RUN) && at_end && !rate_chg;
  assign step_tick = (state_q == ST_STEP) && accept;
  assign tick      = run_tick | step_tick;

  // Counting only continues while RUN persists; any exit or rate change restarts at 0.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN && !rate_chg && !at_end) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q      <= MODE_HALT;
      rate_q      <= '0;
      rate_prev_q <= '0;
      state_q     <= ST_HALT;
      running_q   <= 1'b0;
      cnt_q       <= '0;
      sclk_en_q   <= 1'b0;
      sclk_q      <= 1'b0;
      tick_cnt_q  <= '0;
    end else begin
      mode_q      <= MODE;
      rate_q      <= RATE_SEL;
      rate_prev_q <= rate_q;
      state_q     <= state_d;
      running_q   <= (state_d == ST_RUN);
      cnt_q       <= cnt_d;
      sclk_en_q   <= tick;
      if (tick) begin
        sclk_q     <= ~sclk_q;
        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
      end
    end
  end

  assign SCLK_EN  = sclk_en_q;
  assign SCLK     = sclk_q;
  assign TICK_CNT = tick_cnt_q;
  assign RUNNING  = running_q;

endmodule
